// File: rtl/block_scan_sched_pkg.sv
// Shared encodings for the block scan sequencer: block mode codes and
// FSM state constants.
package block_scan_pkg;

  // Encodings driven on blk_mode; 2'b11 is never produced.
  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_REF   = 2'b01;
  localparam logic [1:0] MODE_BLOOM = 2'b10;

  // Sequencer states.
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t REF   = 3'd1;
  localparam state_t GAP   = 3'd2;
  localparam state_t BLOOM = 3'd3;
  localparam state_t DONE  = 3'd4;

endpackage

// File: rtl/block_scan_sched_if.sv
// Controller-side handshake and block-side bus of the block scan sequencer.
// master: the sequencer's view; slave: controller plus block view.
interface block_scan_sched_if #(
  parameter int DIST_WIDTH = 14,
  parameter int CNT_WIDTH  = 8
);
  logic                  start;
  logic [DIST_WIDTH-1:0] start_dist;
  logic                  busy;
  logic                  done;
  logic                  ref_found;
  logic [DIST_WIDTH-1:0] ref_dist_o;
  logic [CNT_WIDTH-1:0]  bloom_cnt;
  logic                  err_timeout;
  logic [1:0]            blk_mode;
  logic [DIST_WIDTH-1:0] blk_distance;
  logic                  blk_contains_ref;
  logic                  blk_contains_bloom;
  logic                  blk_ref_end;
  logic                  blk_bloom_end;
  logic [DIST_WIDTH-1:0] blk_ref_dist;

  modport master (
    input  start, start_dist, blk_contains_ref, blk_contains_bloom,
           blk_ref_end, blk_bloom_end, blk_ref_dist,
    output busy, done, ref_found, ref_dist_o, bloom_cnt, err_timeout,
           blk_mode, blk_distance
  );

  modport slave (
    output start, start_dist, blk_contains_ref, blk_contains_bloom,
           blk_ref_end, blk_bloom_end, blk_ref_dist,
    input  busy, done, ref_found, ref_dist_o, bloom_cnt, err_timeout,
           blk_mode, blk_distance
  );
endinterface

// File: rtl/block_scan_sched_window.sv
// Bloom sweep window: lo/hi bounds around a reference distance, clamped to
// the distance range, plus a flag marking the last sweep point.
module block_scan_window #(
  parameter int DIST_WIDTH = 14,
  parameter int BLOOM_WIN  = 8
) (
  input  logic [DIST_WIDTH-1:0] ref_dist,
  input  logic [DIST_WIDTH-1:0] point,
  output logic [DIST_WIDTH-1:0] lo,
  output logic [DIST_WIDTH-1:0] hi,
  output logic                  is_last
);
  localparam logic [DIST_WIDTH-1:0] WIN_L = BLOOM_WIN[DIST_WIDTH-1:0];
  localparam logic [DIST_WIDTH-1:0] MAX_L = {DIST_WIDTH{1'b1}};

  // Clamp both window edges instead of letting them wrap around.
  always_comb begin
    if (ref_dist >= WIN_L) begin
      lo = ref_dist - WIN_L;
    end else begin
      lo = {DIST_WIDTH{1'b0}};
    end
    if (ref_dist <= (MAX_L - WIN_L)) begin
      hi = ref_dist + WIN_L;
    end else begin
      hi = MAX_L;
    end
    is_last = (point == hi);
  end
endmodule

// File: rtl/block_scan_sched.sv
// Block scan sequencer: reference search followed by a bloom-marking sweep
// over a clamped window around the found reference distance.
// Optional feature macro: BLOCK_SCAN_SCHED_TIMEOUT_EN (wait-for-end timeout).
module block_scan_sched
  import block_scan_pkg::*;
#(
  parameter int DIST_WIDTH = 14,
  parameter int BLOOM_WIN  = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst,
  block_scan_sched_if.master  bus
);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX_L = {CNT_WIDTH{1'b1}};
  localparam logic [DIST_WIDTH-1:0] ONE_D_L   = {{(DIST_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  ONE_C_L   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r;
  state_t                next_state_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  ref_found_r;
  logic [DIST_WIDTH-1:0] ref_dist_r;
  logic [CNT_WIDTH-1:0]  bloom_cnt_r;
  logic                  err_timeout_r;
  logic [1:0]            blk_mode_r;
  logic [DIST_WIDTH-1:0] blk_distance_r;
  logic [DIST_WIDTH-1:0] win_ref_s;
  logic [DIST_WIDTH-1:0] lo_s;
  logic [DIST_WIDTH-1:0] hi_s;
  logic                  is_last_s;
  logic                  tmo_hit_s;

`ifdef BLOCK_SCAN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST_L = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt_r;

  // Wait counter: runs while waiting for an *_end, zero in every other state so each entry restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else if ((state_r == REF) || (state_r == BLOOM)) begin
      tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r <= {TW{1'b0}};
    end
  end

  assign tmo_hit_s = ((state_r == REF) || (state_r == BLOOM)) && (tmo_cnt_r == TMO_LAST_L);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Window source: the block's live ref_dist while leaving REF, the captured one during the sweep.
  always_comb begin
    if (state_r == REF) begin
      win_ref_s = bus.blk_ref_dist;
    end else begin
      win_ref_s = ref_dist_r;
    end
  end

  block_scan_window #(
    .DIST_WIDTH (DIST_WIDTH),
    .BLOOM_WIN  (BLOOM_WIN)
  ) u_window (
    .ref_dist (win_ref_s),
    .point    (blk_distance_r),
    .lo       (lo_s),
    .hi       (hi_s),
    .is_last  (is_last_s)
  );

  // Next-state logic; an *_end takes priority over a coincident timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) next_state_s = REF;
        else           next_state_s = IDLE;
      end
      REF: begin
        if (bus.blk_ref_end) begin
          if (bus.blk_contains_ref) next_state_s = GAP;
          else                      next_state_s = DONE;
        end else if (tmo_hit_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = REF;
        end
      end
      GAP: next_state_s = BLOOM;
      BLOOM: begin
        if (bus.blk_bloom_end) begin
          if (is_last_s) next_state_s = DONE;
          else           next_state_s = GAP;
        end else if (tmo_hit_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = BLOOM;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, registered outputs and scan results; outputs are derived from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      ref_found_r    <= 1'b0;
      ref_dist_r     <= {DIST_WIDTH{1'b0}};
      bloom_cnt_r    <= {CNT_WIDTH{1'b0}};
      err_timeout_r  <= 1'b0;
      blk_mode_r     <= MODE_IDLE;
      blk_distance_r <= {DIST_WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (next_state_s == DONE);
      case (next_state_s)
        REF:     blk_mode_r <= MODE_REF;
        BLOOM:   blk_mode_r <= MODE_BLOOM;
        default: blk_mode_r <= MODE_IDLE;
      endcase
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            ref_found_r    <= 1'b0;
            ref_dist_r     <= {DIST_WIDTH{1'b0}};
            bloom_cnt_r    <= {CNT_WIDTH{1'b0}};
            err_timeout_r  <= 1'b0;
            blk_distance_r <= bus.start_dist;
          end
        end
        REF: begin
          if (bus.blk_ref_end) begin
            if (bus.blk_contains_ref) begin
              ref_found_r    <= 1'b1;
              ref_dist_r     <= bus.blk_ref_dist;
              blk_distance_r <= lo_s;
            end
          end else if (tmo_hit_s) begin
            err_timeout_r <= 1'b1;
          end
        end
        BLOOM: begin
          if (bus.blk_bloom_end) begin
            if (bus.blk_contains_bloom && (bloom_cnt_r != CNT_MAX_L)) begin
              bloom_cnt_r <= bloom_cnt_r + ONE_C_L;
            end
            if (!is_last_s) begin
              blk_distance_r <= blk_distance_r + ONE_D_L;
            end
          end else if (tmo_hit_s) begin
            err_timeout_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.ref_found    = ref_found_r;
  assign bus.ref_dist_o   = ref_dist_r;
  assign bus.bloom_cnt    = bloom_cnt_r;
`ifdef BLOCK_SCAN_SCHED_TIMEOUT_EN
  assign bus.err_timeout  = err_timeout_r;
`else
  assign bus.err_timeout  = 1'b0;
`endif
  assign bus.blk_mode     = blk_mode_r;
  assign bus.blk_distance = blk_distance_r;
endmodule
